// File: rtl/fifo_read_stream.sv
// FIFO read port (empty/inc, combinational data) to valid/ready stream via a 2-entry head/tail skid buffer.
// First word valid one cycle after the fetch edge; fetch stops when both entries are full, never from i_ready.
module fifo_read_stream #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_arst,
   input  logic              i_empty,
   input  logic [DATA_W-1:0] i_rData,
   output logic              o_inc,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [1:0]        o_level
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;
   logic [DATA_W-1:0] w_next_head;
   logic [DATA_W-1:0] w_next_tail;
   logic              w_fetch;
   logic              w_pop;

   // Fetch decision looks only at buffer occupancy so o_inc has no path from i_ready.
   assign w_fetch = ~i_arst & ~i_empty & (r_state != S_TWO);
   assign w_pop   = (r_state != S_EMPTY) & i_ready;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_state <= S_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_next_state;
         r_head  <= w_next_head;
         r_tail  <= w_next_tail;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_head  = r_head;
      w_next_tail  = r_tail;
      case (r_state)
         S_EMPTY: begin
            if (w_fetch) begin
               w_next_state = S_ONE;
               w_next_head  = i_rData;
            end
         end
         S_ONE: begin
            if (w_fetch && w_pop) begin
               w_next_head = i_rData;
            end else if (w_fetch) begin
               w_next_state = S_TWO;
               w_next_tail  = i_rData;
            end else if (w_pop) begin
               w_next_state = S_EMPTY;
            end
         end
         S_TWO: begin
            if (w_pop) begin
               w_next_state = S_ONE;
               w_next_head  = r_tail;
            end
         end
         default: begin
            w_next_state = S_EMPTY;
         end
      endcase
   end

   assign o_inc   = w_fetch;
   assign o_valid = (r_state != S_EMPTY);
   assign o_data  = r_head;
   assign o_level = r_state;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: queue-based occupancy model plus FIFO-order scoreboard, with literal checks.
module tb_fifo_read_stream;

   localparam int DATA_W = 8;

   logic              i_clk = 1'b0;
   logic              i_arst;
   logic              i_empty;
   logic [DATA_W-1:0] i_rData;
   logic              o_inc;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_data;
   logic [1:0]        o_level;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] src[$];   // words still in the upstream FIFO
   logic [DATA_W-1:0] sent[$];  // words owed downstream, in order
   logic [DATA_W-1:0] mq[$];    // words the skid buffer should be holding

   fifo_read_stream #(.DATA_W(DATA_W)) dut (
      .i_clk   (i_clk),
      .i_arst  (i_arst),
      .i_empty (i_empty),
      .i_rData (i_rData),
      .o_inc   (o_inc),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_level (o_level)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [DATA_W-1:0] w);
      src.push_back(w);
      sent.push_back(w);
   endtask

   task automatic drive(input bit force_e, input bit rdy);
      i_ready = rdy;
      i_empty = force_e || (src.size() == 0);
      i_rData = (src.size() != 0) ? src[0] : 8'hEE;
   endtask

   task automatic cyc(input bit force_e, input bit rdy);
      @(posedge i_clk);
      #2;
      drive(force_e, rdy);
      #1;
   endtask

   // Occupancy model: the buffer is a queue of at most two words.
   always @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         mq.delete();
      end else begin
         bit do_pop;
         bit do_inc;
         do_pop = (mq.size() != 0) && i_ready;
         do_inc = !i_empty && (mq.size() < 2);
         if (do_pop) void'(mq.pop_front());
         if (do_inc && src.size() != 0) mq.push_back(src.pop_front());
      end
   end

   // Per-cycle comparison against the model and the FIFO-order scoreboard.
   always @(negedge i_clk) begin
      check("inc", o_inc, !i_arst && !i_empty && (mq.size() < 2));
      check("level", o_level, mq.size());
      check("valid", o_valid, mq.size() != 0);
      if (mq.size() != 0) check("data", o_data, mq[0]);
      if (o_valid && i_ready && !i_arst) begin
         if (sent.size() == 0) check("extra_word", o_data, 32'hFFFF_FFFF);
         else check("order", o_data, sent.pop_front());
      end
   end

   initial begin
      i_arst  = 1'b1;
      i_empty = 1'b1;
      i_ready = 1'b0;
      i_rData = '0;
      // Reset holds everything off even with data available.
      #3;
      src.push_back(8'hA5);
      i_empty = 1'b0;
      i_rData = 8'hA5;
      #1;
      check("rst_inc", o_inc, 0);
      check("rst_valid", o_valid, 0);
      check("rst_level", o_level, 0);
      @(posedge i_clk);
      @(posedge i_clk);
      #2;
      src.delete();
      sent.delete();
      repeat (3) push(8'hA5);
      i_arst = 1'b0;
      drive(0, 0);
      #1;
      check("fill_inc0", o_inc, 1);
      check("fill_lvl0", o_level, 0);
      cyc(0, 0);
      check("fill_inc1", o_inc, 1);
      check("fill_lvl1", o_level, 1);
      check("fill_dat1", o_data, 8'hA5);
      cyc(0, 0);
      check("fill_inc2", o_inc, 0);
      check("fill_lvl2", o_level, 2);
      cyc(0, 0);
      check("hold_lvl", o_level, 2);
      check("hold_dat", o_data, 8'hA5);
      check("hold_inc", o_inc, 0);

      // Drain two with the FIFO reported empty.
      cyc(1, 1);
      check("drain_v0", o_valid, 1);
      check("drain_inc0", o_inc, 0);
      cyc(1, 1);
      check("drain_lvl1", o_level, 1);
      check("drain_inc1", o_inc, 0);
      cyc(1, 1);
      check("drain_v2", o_valid, 0);
      check("drain_lvl2", o_level, 0);

      // Asynchronous reset while full.
      push(8'h11);
      push(8'h22);
      cyc(0, 0);
      cyc(0, 0);
      cyc(0, 0);
      check("pre_rst_lvl", o_level, 2);
      check("pre_rst_dat", o_data, 8'hA5);
      #1;
      i_arst = 1'b1;
      src.delete();
      sent.delete();
      #1;
      check("arst_valid", o_valid, 0);
      check("arst_level", o_level, 0);
      check("arst_inc", o_inc, 0);
      check("arst_data", o_data, 0);
      @(posedge i_clk);
      #2;
      i_arst = 1'b0;
      push(8'h33);
      drive(0, 1);
      #1;
      check("resume_inc", o_inc, 1);
      cyc(0, 1);
      check("resume_dat", o_data, 8'h33);
      check("resume_v", o_valid, 1);
      cyc(0, 1);
      check("resume_empty", o_level, 0);

      // Streaming one word per cycle.
      for (int k = 1; k <= 16; k++) push(k[7:0]);
      cyc(0, 1);
      check("stream_inc", o_inc, 1);
      for (int k = 1; k <= 16; k++) begin
         cyc(0, 1);
         check("stream_dat", o_data, k);
         check("stream_lvl", o_level, 1);
      end
      cyc(0, 1);
      check("stream_end", o_level, 0);

      // Empty toggling every cycle.
      for (int i = 0; i < 20; i++) push(8'h40 + i[7:0]);
      for (int i = 0; i < 60; i++) cyc(i[0], 1);
      for (int i = 0; i < 5; i++) cyc(0, 1);
      check("toggle_drained", sent.size(), 0);

      // Random backpressure and gaps over 1000 words.
      for (int i = 0; i < 1000; i++) push(8'($urandom));
      for (int i = 0; i < 6000 && (src.size() != 0 || mq.size() != 0); i++)
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      for (int i = 0; i < 4; i++) cyc(0, 1);
      check("rand_src_done", src.size(), 0);
      check("rand_drained", sent.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
